// File: rtl/tcam_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tcam_search_ctrl_if
// Purpose  : Bundles the client request/response handshake and the TCAM
//            SRAM port of tcam_search_ctrl.
// Ports    : none (signal bundle only)
//   slave  : controller view (requests/rdata in, response/memory drive out)
//   master : client + memory view (mirror of slave)
// Revision : 1.0  initial release
// ============================================================================
interface tcam_search_ctrl_if #(
   parameter int KEY_W   = 28,
   parameter int SLICE_W = 7,
   parameter int ENTRIES = 64
);
   localparam int NUM_SLICES = KEY_W / SLICE_W;
   localparam int ADDR_W     = $clog2(NUM_SLICES) + SLICE_W;
   localparam int IDX_W      = $clog2(ENTRIES);
   localparam int WMASK_W    = ENTRIES / 8;

   // client request
   logic                in_req_valid;
   logic                out_req_ready;
   logic                in_req_op;
   logic [KEY_W-1:0]    in_req_key;
   logic [ADDR_W-1:0]   in_req_addr;
   logic [ENTRIES-1:0]  in_req_wdata;
   logic [WMASK_W-1:0]  in_req_wmask;
   // client response
   logic                out_rsp_valid;
   logic                in_rsp_ready;
   logic                out_rsp_hit;
   logic [IDX_W-1:0]    out_rsp_index;
   logic [ENTRIES-1:0]  out_rsp_vector;
   // memory port
   logic                out_mem_csb;
   logic                out_mem_web;
   logic [WMASK_W-1:0]  out_mem_wmask;
   logic [ADDR_W-1:0]   out_mem_addr;
   logic [ENTRIES-1:0]  out_mem_wdata;
   logic [ENTRIES-1:0]  in_mem_rdata;

   modport slave (
      input  in_req_valid, in_req_op, in_req_key, in_req_addr, in_req_wdata,
             in_req_wmask, in_rsp_ready, in_mem_rdata,
      output out_req_ready, out_rsp_valid, out_rsp_hit, out_rsp_index,
             out_rsp_vector, out_mem_csb, out_mem_web, out_mem_wmask,
             out_mem_addr, out_mem_wdata
   );

   modport master (
      output in_req_valid, in_req_op, in_req_key, in_req_addr, in_req_wdata,
             in_req_wmask, in_rsp_ready, in_mem_rdata,
      input  out_req_ready, out_rsp_valid, out_rsp_hit, out_rsp_index,
             out_rsp_vector, out_mem_csb, out_mem_web, out_mem_wmask,
             out_mem_addr, out_mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/tcam_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tcam_search_ctrl
// Purpose  : TCAM search/update controller. A search reads one SRAM row per
//            key slice on consecutive cycles, ANDs the match vectors and
//            priority-encodes the lowest matching entry. Row writes share the
//            same memory port and request/response handshake.
// Ports    : in_clk   - clock, all state on rising edge
//            in_rst   - asynchronous active-high reset
//            bus      - tcam_search_ctrl_if.slave (request, response, memory)
// Revision : 1.0  initial release
// ============================================================================
module tcam_search_ctrl #(
   parameter int KEY_W   = 28,
   parameter int SLICE_W = 7,
   parameter int ENTRIES = 64
) (
   input  logic              in_clk,
   input  logic              in_rst,
   tcam_search_ctrl_if.slave bus
);
   localparam int NUM_SLICES = KEY_W / SLICE_W;
   localparam int BANK_W     = $clog2(NUM_SLICES);
   localparam int ADDR_W     = BANK_W + SLICE_W;
   localparam int IDX_W      = $clog2(ENTRIES);
   localparam int WMASK_W    = ENTRIES / 8;
   localparam int CNT_W      = (BANK_W > 0) ? BANK_W : 1;

   localparam logic [CNT_W-1:0] c_LAST_SLICE = CNT_W'(NUM_SLICES - 1);

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_WRITE  = 3'd1;
   localparam logic [2:0] c_ST_SEARCH = 3'd2;
   localparam logic [2:0] c_ST_DRAIN  = 3'd3;
   localparam logic [2:0] c_ST_RESP   = 3'd4;

   generate
      if ((KEY_W < SLICE_W) || ((KEY_W % SLICE_W) != 0)) begin : g_bad_key_w
         $error("tcam_search_ctrl: KEY_W must be a non-zero multiple of SLICE_W");
      end
      if ((ENTRIES < 8) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
         $error("tcam_search_ctrl: ENTRIES must be a power of 2 and at least 8");
      end
   endgenerate

   logic [2:0]          state_q,  state_d;
   logic [KEY_W-1:0]    key_q,    key_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [ENTRIES-1:0]  acc_q,    acc_d;
   logic [ADDR_W-1:0]   waddr_q,  waddr_d;
   logic [ENTRIES-1:0]  wdata_q,  wdata_d;
   logic [WMASK_W-1:0]  wmask_q,  wmask_d;
   logic                hit_q,    hit_d;
   logic [IDX_W-1:0]    index_q,  index_d;
   logic [ENTRIES-1:0]  vector_q, vector_d;

   logic [SLICE_W-1:0]  w_key_slice;
   logic [ADDR_W-1:0]   w_search_addr;
   logic [ENTRIES-1:0]  w_final;
   logic [IDX_W-1:0]    w_first_idx;

   // Slice 0 takes the key LSBs; bank number sits above the row bits.
   assign w_key_slice   = SLICE_W'(key_q >> (32'(cnt_q) * SLICE_W));
   assign w_search_addr = ADDR_W'({cnt_q, w_key_slice});

   // Last slice's data arrives while in DRAIN, so it is folded in here.
   assign w_final = acc_q & bus.in_mem_rdata;

   // Lowest set bit wins; descending scan lets the lowest index overwrite.
   always_comb begin
      w_first_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (w_final[i]) begin
            w_first_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      hit_d    = hit_q;
      index_d  = index_q;
      vector_d = vector_q;
      case (state_q)
         c_ST_IDLE: begin
            if (bus.in_req_valid) begin
               if (bus.in_req_op) begin
                  waddr_d = bus.in_req_addr;
                  wdata_d = bus.in_req_wdata;
                  wmask_d = bus.in_req_wmask;
                  state_d = c_ST_WRITE;
               end else begin
                  key_d   = bus.in_req_key;
                  cnt_d   = '0;
                  acc_d   = '1;
                  state_d = c_ST_SEARCH;
               end
            end
         end
         c_ST_WRITE: begin
            hit_d    = 1'b0;
            index_d  = '0;
            vector_d = '0;
            state_d  = c_ST_RESP;
         end
         c_ST_SEARCH: begin
            // rdata lags the address by one cycle: nothing to fold on slice 0.
            if (cnt_q != '0) begin
               acc_d = acc_q & bus.in_mem_rdata;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == c_LAST_SLICE) begin
               state_d = c_ST_DRAIN;
            end
         end
         c_ST_DRAIN: begin
            acc_d    = w_final;
            vector_d = w_final;
            hit_d    = |w_final;
            index_d  = w_first_idx;
            state_d  = c_ST_RESP;
         end
         c_ST_RESP: begin
            if (bus.in_rsp_ready) begin
               state_d = c_ST_IDLE;
            end
         end
         default: state_d = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q  <= c_ST_IDLE;
         key_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '1;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         hit_q    <= 1'b0;
         index_q  <= '0;
         vector_q <= '0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         hit_q    <= hit_d;
         index_q  <= index_d;
         vector_q <= vector_d;
      end
   end

   // Memory port decodes from state only, so reset deselects it immediately.
   always_comb begin
      bus.out_mem_csb   = 1'b1;
      bus.out_mem_web   = 1'b1;
      bus.out_mem_addr  = '0;
      bus.out_mem_wdata = '0;
      bus.out_mem_wmask = '0;
      if (state_q == c_ST_SEARCH) begin
         bus.out_mem_csb  = 1'b0;
         bus.out_mem_addr = w_search_addr;
      end else if (state_q == c_ST_WRITE) begin
         bus.out_mem_csb   = 1'b0;
         bus.out_mem_web   = 1'b0;
         bus.out_mem_addr  = waddr_q;
         bus.out_mem_wdata = wdata_q;
         bus.out_mem_wmask = wmask_q;
      end
   end

   assign bus.out_req_ready  = (state_q == c_ST_IDLE);
   assign bus.out_rsp_valid  = (state_q == c_ST_RESP);
   assign bus.out_rsp_hit    = hit_q;
   assign bus.out_rsp_index  = index_q;
   assign bus.out_rsp_vector = vector_q;
endmodule
`default_nettype wire

// File: tb/tb_tcam_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcam_search_ctrl
// Purpose  : Self-checking bench for tcam_search_ctrl with an SRAM model and
//            a behavioural search reference model.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_tcam_search_ctrl;
   localparam int KEY_W    = 28;
   localparam int SLICE_W  = 7;
   localparam int ENTRIES  = 64;
   localparam int NS       = KEY_W / SLICE_W;
   localparam int ADDR_W   = 9;
   localparam int IDX_W    = 6;
   localparam int WM_W     = ENTRIES / 8;
   localparam int MEM_ROWS = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [ENTRIES-1:0] mem     [MEM_ROWS];
   logic [ENTRIES-1:0] ref_mem [MEM_ROWS];

   tcam_search_ctrl_if #(.KEY_W(KEY_W), .SLICE_W(SLICE_W), .ENTRIES(ENTRIES)) bus ();

   tcam_search_ctrl #(.KEY_W(KEY_W), .SLICE_W(SLICE_W), .ENTRIES(ENTRIES)) dut (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Deterministic, fairly dense initial contents so AND-ed searches hit often.
   function automatic logic [ENTRIES-1:0] init_row(input int a);
      logic [31:0] x;
      logic [31:0] y;
      x = 32'(a) * 32'h9E37_79B1;
      y = (32'(a) + 32'd7) * 32'h85EB_CA6B;
      return {x, y} | {y ^ (x >> 7), x ^ (y << 3)};
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input logic [KEY_W-1:0] key, input int k);
      int a;
      a = k * (1 << SLICE_W) + int'((key >> (k * SLICE_W)) & KEY_W'((1 << SLICE_W) - 1));
      return a[ADDR_W-1:0];
   endfunction

   task automatic ref_search(input logic [KEY_W-1:0] key, output logic [ENTRIES-1:0] vec,
                             output logic hit, output logic [IDX_W-1:0] idx);
      bit found;
      vec = '1;
      for (int k = 0; k < NS; k++) vec = vec & ref_mem[addr_of(key, k)];
      hit   = (vec != '0);
      idx   = '0;
      found = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!found && vec[i]) begin
            idx   = IDX_W'(i);
            found = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SRAM model: request sampled mid-cycle (outputs are stable then), applied at posedge.
   initial begin
      logic              s_csb, s_web;
      logic [ADDR_W-1:0] s_addr;
      logic [ENTRIES-1:0] s_wdata;
      logic [WM_W-1:0]   s_wmask;
      for (int a = 0; a < MEM_ROWS; a++) mem[a] = init_row(a);
      bus.in_mem_rdata = '0;
      forever begin
         @(negedge clk);
         s_csb   = bus.out_mem_csb;
         s_web   = bus.out_mem_web;
         s_addr  = bus.out_mem_addr;
         s_wdata = bus.out_mem_wdata;
         s_wmask = bus.out_mem_wmask;
         @(posedge clk);
         if (!rst && !s_csb) begin
            if (!s_web) begin
               for (int b = 0; b < WM_W; b++)
                  if (s_wmask[b]) mem[s_addr][b*8 +: 8] = s_wdata[b*8 +: 8];
            end else begin
               bus.in_mem_rdata <= mem[s_addr];
            end
         end
      end
   end

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ENTRIES-1:0] d,
                           input logic [WM_W-1:0] m);
      chk("wr_ready", 64'(bus.out_req_ready), 64'd1);
      bus.in_req_valid = 1'b1;
      bus.in_req_op    = 1'b1;
      bus.in_req_addr  = a;
      bus.in_req_wdata = d;
      bus.in_req_wmask = m;
      @(posedge clk);
      @(negedge clk);
      bus.in_req_valid = 1'b0;
      chk("wr_csb",   64'(bus.out_mem_csb), 64'd0);
      chk("wr_web",   64'(bus.out_mem_web), 64'd0);
      chk("wr_addr",  64'(bus.out_mem_addr), 64'(a));
      chk("wr_wdata", 64'(bus.out_mem_wdata), 64'(d));
      chk("wr_wmask", 64'(bus.out_mem_wmask), 64'(m));
      chk("wr_early_valid", 64'(bus.out_rsp_valid), 64'd0);
      for (int b = 0; b < WM_W; b++) if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      @(negedge clk);
      chk("wr_one_cycle_csb", 64'(bus.out_mem_csb), 64'd1);
      chk("wr_rsp_valid", 64'(bus.out_rsp_valid), 64'd1);
      chk("wr_rsp_hit",   64'(bus.out_rsp_hit), 64'd0);
      chk("wr_rsp_index", 64'(bus.out_rsp_index), 64'd0);
      chk("wr_rsp_vector", 64'(bus.out_rsp_vector), 64'd0);
      chk("wr_mem_row", 64'(mem[a]), 64'(ref_mem[a]));
      bus.in_rsp_ready = 1'b1;
      @(negedge clk);
      chk("wr_ready_back", 64'(bus.out_req_ready), 64'd1);
      chk("wr_valid_drop", 64'(bus.out_rsp_valid), 64'd0);
      bus.in_rsp_ready = 1'b0;
   endtask

   // stall: cycles the response is held off; pend: raise a write request during the stall.
   task automatic do_search(input logic [KEY_W-1:0] key, input int stall, input bit pend,
                            input logic [ADDR_W-1:0] pa, input logic [ENTRIES-1:0] pd,
                            input logic [WM_W-1:0] pm);
      logic [ENTRIES-1:0] ev;
      logic               eh;
      logic [IDX_W-1:0]   ei;
      ref_search(key, ev, eh, ei);
      chk("sr_ready", 64'(bus.out_req_ready), 64'd1);
      bus.in_req_valid = 1'b1;
      bus.in_req_op    = 1'b0;
      bus.in_req_key   = key;
      @(posedge clk);
      @(negedge clk);
      bus.in_req_valid = 1'b0;
      for (int k = 0; k < NS; k++) begin
         chk("sr_csb",  64'(bus.out_mem_csb), 64'd0);
         chk("sr_web",  64'(bus.out_mem_web), 64'd1);
         chk("sr_addr", 64'(bus.out_mem_addr), 64'(addr_of(key, k)));
         chk("sr_early_valid", 64'(bus.out_rsp_valid), 64'd0);
         @(negedge clk);
      end
      chk("drain_csb",   64'(bus.out_mem_csb), 64'd1);
      chk("drain_valid", 64'(bus.out_rsp_valid), 64'd0);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid",  64'(bus.out_rsp_valid), 64'd1);
         chk("rsp_hit",    64'(bus.out_rsp_hit), 64'(eh));
         chk("rsp_index",  64'(bus.out_rsp_index), 64'(ei));
         chk("rsp_vector", 64'(bus.out_rsp_vector), 64'(ev));
         chk("rsp_ready_low", 64'(bus.out_req_ready), 64'd0);
         chk("rsp_mem_idle", 64'(bus.out_mem_csb), 64'd1);
         if (pend && s == 0) begin
            bus.in_req_valid = 1'b1;
            bus.in_req_op    = 1'b1;
            bus.in_req_addr  = pa;
            bus.in_req_wdata = pd;
            bus.in_req_wmask = pm;
         end
         if (s == stall) bus.in_rsp_ready = 1'b1;
         @(negedge clk);
      end
      chk("sr_ready_back", 64'(bus.out_req_ready), 64'd1);
      chk("sr_valid_drop", 64'(bus.out_rsp_valid), 64'd0);
      chk("sr_no_early_write", 64'(bus.out_mem_csb), 64'd1);
      bus.in_rsp_ready = 1'b0;
   endtask

   initial begin
      logic [KEY_W-1:0]   rk;
      logic [ADDR_W-1:0]  ra;
      logic [ENTRIES-1:0] rd;
      logic [WM_W-1:0]    rm;
      for (int a = 0; a < MEM_ROWS; a++) ref_mem[a] = init_row(a);
      bus.in_req_valid = 1'b0;
      bus.in_req_op    = 1'b0;
      bus.in_req_key   = '0;
      bus.in_req_addr  = '0;
      bus.in_req_wdata = '0;
      bus.in_req_wmask = '0;
      bus.in_rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready",  64'(bus.out_req_ready), 64'd1);
      chk("rst_valid",  64'(bus.out_rsp_valid), 64'd0);
      chk("rst_hit",    64'(bus.out_rsp_hit), 64'd0);
      chk("rst_index",  64'(bus.out_rsp_index), 64'd0);
      chk("rst_vector", 64'(bus.out_rsp_vector), 64'd0);
      chk("rst_csb",    64'(bus.out_mem_csb), 64'd1);
      chk("rst_web",    64'(bus.out_mem_web), 64'd1);
      chk("rst_addr",   64'(bus.out_mem_addr), 64'd0);
      chk("rst_wdata",  64'(bus.out_mem_wdata), 64'd0);
      chk("rst_wmask",  64'(bus.out_mem_wmask), 64'd0);

      // Write row 0x005 then search key 5 with bit 4 in every slice row
      do_write(9'h005, 64'h10, 8'hFF);
      do_write(9'h080, 64'h10, 8'hFF);
      do_write(9'h100, 64'h10, 8'hFF);
      do_write(9'h180, 64'h10, 8'hFF);
      do_search(28'h0000005, 0, 0, '0, '0, '0);

      // Slice 2 row empty: no hit
      rk = 28'h1234567;
      do_write(addr_of(rk, 0), '1, 8'hFF);
      do_write(addr_of(rk, 1), '1, 8'hFF);
      do_write(addr_of(rk, 2), '0, 8'hFF);
      do_write(addr_of(rk, 3), '1, 8'hFF);
      do_search(rk, 0, 0, '0, '0, '0);

      // Mixed vectors: F0 & FF0000F0 & 30 & FFFF -> 30, index 4
      rk = 28'h0ABCDEF;
      do_write(addr_of(rk, 0), 64'hF0, 8'hFF);
      do_write(addr_of(rk, 1), 64'hFF00_00F0, 8'hFF);
      do_write(addr_of(rk, 2), 64'h30, 8'hFF);
      do_write(addr_of(rk, 3), 64'hFFFF, 8'hFF);
      do_search(rk, 0, 0, '0, '0, '0);

      // Response held for 10 cycles with a write request pending meanwhile
      do_search(rk, 10, 1, 9'h1A3, 64'hDEAD_BEEF_0123_4567, 8'h5A);
      do_write(9'h1A3, 64'hDEAD_BEEF_0123_4567, 8'h5A);

      // Reset in the middle of a search
      bus.in_req_valid = 1'b1;
      bus.in_req_op    = 1'b0;
      bus.in_req_key   = 28'h0FEDCBA;
      @(posedge clk);
      @(negedge clk);
      bus.in_req_valid = 1'b0;
      @(negedge clk);
      chk("midrst_pre_csb", 64'(bus.out_mem_csb), 64'd0);
      rst = 1'b1;
      #1;
      chk("midrst_csb",   64'(bus.out_mem_csb), 64'd1);
      chk("midrst_valid", 64'(bus.out_rsp_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(bus.out_req_ready), 64'd1);
      chk("midrst_valid_after", 64'(bus.out_rsp_valid), 64'd0);
      do_search(28'h0FEDCBA, 0, 0, '0, '0, '0);

      // Randomised writes (random masks) and searches against the model
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            ra = ADDR_W'($urandom);
            rd = {$urandom, $urandom};
            rm = WM_W'($urandom);
            do_write(ra, rd, rm);
         end else begin
            rk = KEY_W'($urandom);
            do_search(rk, int'($urandom_range(0, 2)), 0, '0, '0, '0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tcam_search_ctrl.md
# tcam_search_ctrl

Parametrised TCAM search/update controller that sits between a request/response client (RoCC command path) and an SRAM-backed TCAM array organised as NUM_SLICES banks of 2^SLICE_W rows × ENTRIES match bits. A search splits the key into SLICE_W-bit slices and reads one row per slice over back-to-back cycles. It ANDs the returned match vectors and priority-encodes the result. Row writes pass through the same memory port under the same handshake.

## Interface
Parameters:
- KEY_W, 28, search key width; must be a multiple of SLICE_W (elaboration error otherwise)
- SLICE_W, 7, key bits per slice = row address bits per bank
- ENTRIES, 64, TCAM entries = match-vector width; power of 2, ≥ 8
- Derived: NUM_SLICES = KEY_W/SLICE_W; ADDR_W = clog2(NUM_SLICES)+SLICE_W; IDX_W = clog2(ENTRIES)

Ports:
- in_clk  input  1  clock, all state on rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_req_valid  input  1  request valid
- out_req_ready  output  1  controller can accept; high only in IDLE
- in_req_op  input  1  0 = search, 1 = row write
- in_req_key  input  KEY_W  search key
- in_req_addr  input  ADDR_W  write row address
- in_req_wdata  input  ENTRIES  write row data
- in_req_wmask  input  ENTRIES/8  write byte mask
- out_rsp_valid  output  1  response valid
- in_rsp_ready  input  1  client accepts response
- out_rsp_hit  output  1  search found ≥1 match
- out_rsp_index  output  IDX_W  lowest matching entry index
- out_rsp_vector  output  ENTRIES  final AND-ed match vector
- out_mem_csb  output  1  memory chip select, active low
- out_mem_web  output  1  memory write enable, active low
- out_mem_wmask  output  ENTRIES/8  memory byte mask
- out_mem_addr  output  ADDR_W  memory row address
- out_mem_wdata  output  ENTRIES  memory write data
- in_mem_rdata  input  ENTRIES  memory read data, valid one cycle after the read address edge

## Operation
- States: IDLE, WRITE, SEARCH, DRAIN, RESP.
- IDLE: out_req_ready=1; memory idle (csb=1, web=1, addr/wdata/wmask=0). An accept (valid&ready) with op=0 latches the key, clears the slice counter, sets the accumulator to all ones and goes to SEARCH. With op=1 it latches addr, wdata and wmask and goes to WRITE.
- SEARCH: drives csb=0, web=1, addr={slice_cnt, key[slice_cnt*SLICE_W +: SLICE_W]}.
  - Each cycle after the first, ANDs in_mem_rdata into the accumulator.
  - slice_cnt increments; after slice NUM_SLICES-1 is issued, go to DRAIN.
- DRAIN: memory idle; AND the final rdata; register vector, hit = |vector, index = lowest set bit (0 when no hit); go to RESP.
- WRITE: one cycle, csb=0, web=0, addr/wdata/wmask from the latched request; response fields hit=0, index=0, vector=0; go to RESP.
- RESP: out_rsp_valid=1 with fields stable; on in_rsp_ready go to IDLE. Requests are not accepted in RESP.
- Slice 0 always uses key LSBs. Bank address bits wrap naturally; NUM_SLICES not a power of 2 leaves unused banks untouched.

## Timing
- Reset (async assert, sync release): state=IDLE. out_req_ready=1 after reset is released. out_rsp_valid=0, hit=0, index=0, vector=0, csb=1, web=1, mem addr/wdata/wmask=0. Accumulator is all ones.
- Search acceptance at edge E0:
  - Slice k address is driven between E(k) and E(k+1).
  - Slice k data is captured at E(k+2).
  - out_rsp_valid rises at E(NUM_SLICES+1), which is 5 edges for the defaults.
- Write acceptance at E0: memory write is issued between E0 and E1; out_rsp_valid rises at E1.
- out_req_ready returns at the edge after the response handshake. Minimum back-to-back search period is NUM_SLICES+3 cycles with in_rsp_ready held high.
- Reset mid-operation: memory deselected immediately and the in-flight response is discarded. No partial write beyond the cycle already in progress.
- in_req_valid outside IDLE is ignored; the client must hold the request until ready.

## Test plan
- Reset with in_rst=1 mid-SEARCH -> csb=1 within the same cycle, out_rsp_valid=0, out_req_ready=1 on the first edge after release.
- Write row 0x005 with data 64'h0000_0000_0000_0010 and mask 8'hFF -> mem web=0, addr=0x005 for exactly one cycle, out_rsp_valid at E1, hit=0.
- Search key 28'h0000005: memory returns bit4 set for all four slices -> addresses 0x005,0x080,0x100,0x180, out_rsp_valid at E5, hit=1, index=4, vector=64'h10.
- Search where slice 2 returns 64'h0 and the other slices return all ones -> hit=0, index=0, vector=0.
- Slices return 64'hF0, 64'hFF00_00F0, 64'h30, 64'hFFFF -> vector=64'h30, index=4.
- Hold in_rsp_ready=0 for 10 cycles -> response fields stable, out_req_ready=0 throughout. A new request asserted meanwhile is accepted only after the handshake.
